// File: rtl/uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Package     : uart_pkg                                               |
// | Description : Shared constants for the UART transmitter: FSM state   |
// |               encoding, parity_mode encoding and the line idle level.|
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package uart_pkg;

  // FSM state encoding, kept as plain constants for legacy tool flows
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  // parity_mode encoding; 2'b11 behaves like no parity
  localparam logic [1:0] PAR_NONE  = 2'b00;
  localparam logic [1:0] PAR_EVEN  = 2'b01;
  localparam logic [1:0] PAR_ODD   = 2'b10;
  localparam logic [1:0] PAR_NONE2 = 2'b11;

  // Level of txd between frames and during stop bits
  localparam logic IDLE_LEVEL = 1'b1;

  // True when the frame carries a parity bit
  function automatic logic has_parity(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : uart_baud_gen                                          |
// | Description : Bit-period tick generator. Emits one tick every        |
// |               max(div,1) clk1 cycles; restart zeroes the count so    |
// |               the following bit gets a full period.                  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] div_eff;

  // Divisor 0 behaves as 1; tick on the last cycle of each bit period
  always_comb begin
    div_eff = (div == '0) ? DIV_W'(1) : div;
    tick    = 1'b0;
    cnt_d   = cnt_q + DIV_W'(1);
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q >= div_eff - DIV_W'(1)) begin
      tick  = 1'b1;
      cnt_d = '0;
    end
  end

  // Period counter register
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : uart_tx_param                                          |
// | Description : Parameterised UART transmitter. Start bit, DATA_W data |
// |               bits LSB first, optional even/odd parity, 1 or 2 stop  |
// |               bits. Frame settings are captured at frame load.       |
// |               Define UART_TX_FIFO_EN for a FIFO_DEPTH-word input     |
// |               FIFO; otherwise a single holding register is used.     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              txd,
  output logic              busy,
  output logic              tx_done
);

  localparam int             BCW      = $clog2(DATA_W);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  // Buffer-to-shifter handshake
  logic              buf_avail;
  logic [DATA_W-1:0] buf_data;
  logic              buf_pop;

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              push;

  // Full FIFO refuses pushes even when a pop happens in the same cycle
  assign in_ready  = (cnt_q != (AW+1)'(FIFO_DEPTH));
  assign push      = in_valid && in_ready;
  assign buf_avail = (cnt_q != '0);
  assign buf_data  = mem_q[rd_q];

  // Ring-buffer pointer and occupancy update
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q] = in_data;
      wr_d        = wr_q + AW'(1);
    end
    if (buf_pop) rd_d = rd_q + AW'(1);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(buf_pop);
  end

  // FIFO storage and pointers
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
`else
  logic              hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;

  assign in_ready  = !hold_valid_q;
  assign buf_avail = hold_valid_q;
  assign buf_data  = hold_data_q;

  // Holding register fills when empty and drains when the shifter loads
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (in_valid && in_ready) begin
      hold_valid_d = 1'b1;
      hold_data_d  = in_data;
    end else if (buf_pop) begin
      hold_valid_d = 1'b0;
    end
  end

  // Holding register
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end
`endif

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              txd_q, txd_d;
  logic              par_q, par_d;
  logic [1:0]        pmode_q, pmode_d;
  logic              stop2_q, stop2_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              restart;
  logic              tick;
  logic              load;

  // Baud divisor is the value captured at frame load
  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk1    (clk1),
    .rst     (rst),
    .restart (restart),
    .div     (div_q),
    .tick    (tick)
  );

  // Frame sequencer; txd is registered from the next-state bit value
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    txd_d      = txd_q;
    par_d      = par_q;
    pmode_d    = pmode_q;
    stop2_d    = stop2_q;
    div_d      = div_q;
    restart    = 1'b0;
    load       = 1'b0;
    buf_pop    = 1'b0;
    tx_done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (buf_avail) begin
          load    = 1'b1;
          restart = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          txd_d     = shift_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            if (has_parity(pmode_q)) begin
              state_d = ST_PARITY;
              txd_d   = par_q;
            end else begin
              state_d    = ST_STOP;
              txd_d      = IDLE_LEVEL;
              stop_cnt_d = 1'b0;
            end
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BCW'(1);
            txd_d     = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d    = ST_STOP;
          txd_d      = IDLE_LEVEL;
          stop_cnt_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            tx_done = 1'b1;
            if (buf_avail) begin
              // Next start bit follows directly; the counter has just wrapped
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
              txd_d   = IDLE_LEVEL;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = IDLE_LEVEL;
      end
    endcase
    if (load) begin
      buf_pop    = 1'b1;
      state_d    = ST_START;
      txd_d      = 1'b0;
      shift_d    = buf_data;
      par_d      = (^buf_data) ^ (parity_mode == PAR_ODD);
      pmode_d    = parity_mode;
      stop2_d    = stop2;
      div_d      = baud_div;
      bit_cnt_d  = '0;
      stop_cnt_d = 1'b0;
    end
  end

  // Sequencer registers
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      txd_q      <= IDLE_LEVEL;
      par_q      <= 1'b0;
      pmode_q    <= PAR_NONE;
      stop2_q    <= 1'b0;
      div_q      <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      txd_q      <= txd_d;
      par_q      <= par_d;
      pmode_q    <= pmode_d;
      stop2_q    <= stop2_d;
      div_q      <= div_d;
    end
  end

  assign txd  = txd_q;
  assign busy = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter DIV_W, default 16, width of the runtime baud divisor.
REQ-003 Parameter FIFO_DEPTH, default 4, number of buffered words (power of two, >=2); used only when UART_TX_FIFO_EN is defined.
REQ-004 Port clk1  input  1  system clock; all logic is in this single domain, with no derived clocks.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port baud_div  input  DIV_W  clk1 cycles per bit; value 0 is treated as 1.
REQ-007 Port parity_mode  input  2  00 none, 01 even, 10 odd, 11 none.
REQ-008 Port stop2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-009 Port in_data  input  DATA_W  word to transmit.
REQ-010 Port in_valid  input  1  in_data is valid.
REQ-011 Port in_ready  output  1  block accepts the word; a word transfers when in_valid and in_ready are both high on a clk1 edge.
REQ-012 Port txd  output  1  serial line; idle level is 1.
REQ-013 Port busy  output  1  high while a frame is on the line.
REQ-014 Port tx_done  output  1  one-cycle pulse when the final stop bit completes.

Function
REQ-015 Frame format SHALL be: start bit 0, data bits LSB first, optional parity bit, then 1 or 2 stop bits at level 1.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP; transitions occur only on a baud tick.
REQ-017 The baud counter SHALL restart when a word loads in IDLE, so every bit, including the start bit, lasts exactly max(baud_div,1) clk1 cycles.
REQ-018 txd SHALL go low on the clk1 edge after a word enters the shifter in IDLE (latency 1 cycle).
REQ-019 The bit counter SHALL count DATA_W bits; DATA leaves to PARITY when parity_mode is 01 or 10, otherwise to STOP.
REQ-020 Even parity SHALL be the XOR of the data bits; odd parity SHALL be its complement.
REQ-021 parity_mode, stop2 and baud_div SHALL be sampled at frame load and held for the whole frame; mid-frame changes apply to the next frame.
REQ-022 At the end of STOP, if another word is available, START SHALL follow immediately with no idle bit; otherwise the FSM returns to IDLE.
REQ-023 tx_done SHALL pulse in the same cycle the FSM leaves STOP.
REQ-024 busy SHALL be high in START, DATA, PARITY and STOP.
REQ-025 Words SHALL never be dropped or duplicated; a word offered while in_ready is low remains the sender's responsibility.

Reset
REQ-026 rst SHALL asynchronously force: txd=1, busy=0, tx_done=0, FSM to IDLE, all counters to 0, and buffer empty.
REQ-027 A reset mid-frame SHALL abort the frame; txd returns to 1 immediately and no tx_done pulse occurs.
REQ-028 After reset, in_ready SHALL be 1.

Configuration
REQ-029 With macro UART_TX_FIFO_EN defined, a FIFO_DEPTH-entry FIFO SHALL sit ahead of the shifter; in_ready = FIFO not full.
REQ-029a In FIFO mode, a simultaneous push and pop on a full FIFO SHALL be refused; the push is blocked by in_ready.
REQ-030 Without UART_TX_FIFO_EN, a single holding register SHALL replace the FIFO; in_ready = holding register empty.

Structure
REQ-031 Package uart_pkg SHALL hold the FSM state enum, the parity_mode encoding constants and the idle-level constant.
REQ-032 Baud tick generation SHALL be a sub-module uart_baud_gen (inputs clk1, rst, restart, div; output tick).

Verification
REQ-033 DATA_W=8, baud_div=4, parity 00, stop2=0, send 0xA5 -> txd pattern 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles; tx_done at cycle 40.
REQ-034 0xA5 with parity_mode 01 -> parity bit 0; with 10 -> parity bit 1; frame is 11 bits.
REQ-035 Back-to-back words 0x01 then 0x80, stop2=1 -> second start bit immediately follows 2 stop bits; no extra idle bit.
REQ-036 FIFO_EN, FIFO_DEPTH=4, baud_div=100, push 7 words continuously -> 5 accepted (1 shifter + 4 FIFO), in_ready low, then all 5 emitted in order.
REQ-037 rst asserted during DATA bit 3 -> txd=1 same cycle, busy=0, no tx_done; next word transmits normally.
REQ-038 baud_div=0 -> each bit lasts 1 cycle; change baud_div mid-frame -> the current frame keeps the old rate.
